// File: rtl/prog_mem_arbiter_pkg.sv
// rtl/prog_mem_arbiter_pkg.sv - shared FSM states, owner ids and slot helper for the program memory arbiter
// Purpose: types and constants used by prog_mem_arbiter and its round-robin picker.
// Contents:
//   state_e    three-phase transaction state (idle, memory access, acknowledge)
//   GNT_HOST   owner id reported on GNT_ID while the host holds the memory
//   next_slot  rotation helper, (slot + 1) mod ns
package prog_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    localparam logic [3:0] GNT_HOST = 4'hF;

    // Slot count never exceeds 9 (8 cores plus host), so 5 bits hold slot + 1.
    function automatic logic [3:0] next_slot(input logic [3:0] slot, input int unsigned ns);
        logic [4:0] n;
        n = {1'b0, slot} + 5'd1;
        if (n >= 5'(ns)) begin
            n = '0;
        end
        return n[3:0];
    endfunction

endpackage

// File: rtl/prog_mem_arbiter_rr_pick.sv
// rtl/prog_mem_arbiter_rr_pick.sv - combinational round-robin priority select
// Purpose: picks the first requesting slot at or after ptr, wrapping modulo N.
// Ports:
//   req_i     N   request per slot
//   ptr_i     4   slot with highest priority this round
//   onehot_o  N   one-hot winner (all zero when nothing requests)
//   idx_o     4   winner index (0 when nothing requests)
//   any_o     1   at least one slot requesting
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [3:0]   ptr_i,
    output logic [N-1:0] onehot_o,
    output logic [3:0]   idx_o,
    output logic         any_o
);

    // Scan from the farthest offset down to offset 0 so the slot nearest ptr overwrites last.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            int s;
            s = (int'(ptr_i) + k) % N;
            if (req_i[s]) begin
                onehot_o    = '0;
                onehot_o[s] = 1'b1;
                idx_o       = 4'(s);
            end
        end
    end

endmodule

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - single-port program memory arbiter for NC core fetch ports plus a host port
// Purpose: serialises core instruction fetches and host program loads/reads onto one memory
//   port as arbitrate / access / acknowledge transactions, one in flight at a time.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   C_REQ/C_A/C_ACK       per-core fetch request, address (core i at [i*AW +: AW]), ack pulse
//   H_REQ/H_WE/H_A/H_DI   host request, write select, address, write data
//   H_ACK                 host ack pulse
//   RDQ                   registered read data, valid with the ack pulse
//   MEM_A/MEM_WE/MEM_DI   memory address, write enable, write data
//   MEM_DQ                asynchronous memory read data
//   BUSY                  transaction in ACCESS or ACK
//   GNT_ID                current/last owner, 0..NC-1 core or 4'hF host
module prog_mem_arbiter
    import prog_mem_arbiter_pkg::*;
#(
    parameter int DW        = 18,
    parameter int AW        = 12,
    parameter int NC        = 4,
    parameter int HOST_PRIO = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NC-1:0]    C_REQ,
    input  logic [NC*AW-1:0] C_A,
    output logic [NC-1:0]    C_ACK,
    input  logic             H_REQ,
    input  logic             H_WE,
    input  logic [AW-1:0]    H_A,
    input  logic [DW-1:0]    H_DI,
    output logic             H_ACK,
    output logic [DW-1:0]    RDQ,
    output logic [AW-1:0]    MEM_A,
    output logic             MEM_WE,
    output logic [DW-1:0]    MEM_DI,
    input  logic [DW-1:0]    MEM_DQ,
    output logic             BUSY,
    output logic [3:0]       GNT_ID
);

    // With host priority only the cores rotate; otherwise the host is rotation slot NC.
    localparam int NS = (HOST_PRIO != 0) ? NC : NC + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   mem_a_q, mem_a_d;
    logic            mem_we_q, mem_we_d;
    logic [DW-1:0]   mem_di_q, mem_di_d;
    logic [DW-1:0]   rdq_q, rdq_d;
    logic [NC-1:0]   c_ack_q, c_ack_d;
    logic            h_ack_q, h_ack_d;
    logic [3:0]      gnt_id_q, gnt_id_d;
    logic [3:0]      ptr_q, ptr_d;

    logic [NS-1:0]   slot_req;
    logic [NS-1:0]   slot_onehot;
    logic [3:0]      slot_idx;
    logic            slot_any;
    logic            pick_host;
    logic [AW-1:0]   core_a;

    generate
        if (HOST_PRIO != 0) begin : g_host_prio
            assign slot_req  = C_REQ;
            assign pick_host = H_REQ;
        end else begin : g_host_rr
            assign slot_req  = {H_REQ, C_REQ};
            assign pick_host = slot_onehot[NC];
        end
    endgenerate

    rr_pick #(
        .N (NS)
    ) u_rr_pick (
        .req_i    (slot_req),
        .ptr_i    (ptr_q),
        .onehot_o (slot_onehot),
        .idx_o    (slot_idx),
        .any_o    (slot_any)
    );

    always_comb begin
        core_a = '0;
        for (int i = 0; i < NC; i++) begin
            if (slot_onehot[i]) begin
                core_a = C_A[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_a_d  = mem_a_q;
        mem_we_d = mem_we_q;
        mem_di_d = mem_di_q;
        rdq_d    = rdq_q;
        c_ack_d  = c_ack_q;
        h_ack_d  = h_ack_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                c_ack_d = '0;
                h_ack_d = 1'b0;
                if (H_REQ || slot_any) begin
                    state_d = ST_ACCESS;
                    if (pick_host) begin
                        mem_a_d  = H_A;
                        mem_we_d = H_WE;
                        if (H_WE) begin
                            mem_di_d = H_DI;
                        end
                        gnt_id_d = GNT_HOST;
                        // Host is the last rotation slot, so the next round starts at core 0.
                        if (HOST_PRIO == 0) begin
                            ptr_d = '0;
                        end
                    end else begin
                        mem_a_d  = core_a;
                        mem_we_d = 1'b0;
                        gnt_id_d = slot_idx;
                        ptr_d    = next_slot(slot_idx, NS);
                    end
                end
            end
            ST_ACCESS: begin
                state_d  = ST_ACK;
                mem_we_d = 1'b0;
                if (!mem_we_q) begin
                    rdq_d = MEM_DQ;
                end
                if (gnt_id_q == GNT_HOST) begin
                    h_ack_d = 1'b1;
                end else begin
                    for (int i = 0; i < NC; i++) begin
                        if (gnt_id_q == 4'(i)) begin
                            c_ack_d[i] = 1'b1;
                        end
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                c_ack_d = '0;
                h_ack_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            mem_di_q <= '0;
            rdq_q    <= '0;
            c_ack_q  <= '0;
            h_ack_q  <= 1'b0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            mem_a_q  <= mem_a_d;
            mem_we_q <= mem_we_d;
            mem_di_q <= mem_di_d;
            rdq_q    <= rdq_d;
            c_ack_q  <= c_ack_d;
            h_ack_q  <= h_ack_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign C_ACK  = c_ack_q;
    assign H_ACK  = h_ack_q;
    assign RDQ    = rdq_q;
    assign MEM_A  = mem_a_q;
    // A write caught by reset must not reach the memory on the edge that samples RST high.
    assign MEM_WE = mem_we_q & ~RST;
    assign MEM_DI = mem_di_q;
    assign BUSY   = (state_q == ST_ACCESS) || (state_q == ST_ACK);
    assign GNT_ID = gnt_id_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb/tb_prog_mem_arbiter.sv - self-checking bench for prog_mem_arbiter
module tb_prog_mem_arbiter;

    localparam int DW = 18;
    localparam int AW = 12;
    localparam int NC = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RST;

    logic [NC-1:0]    c_req, c_ack, c_req0, c_ack0;
    logic [NC*AW-1:0] c_a, c_a0;
    logic             h_req, h_we, h_ack, h_req0, h_we0, h_ack0;
    logic [AW-1:0]    h_a, h_a0, mem_a, mem_a0;
    logic [DW-1:0]    h_di, h_di0, rdq, rdq0, mem_di, mem_di0, mem_dq, mem_dq0;
    logic             mem_we, mem_we0, busy, busy0;
    logic [3:0]       gnt_id, gnt_id0;

    logic [DW-1:0] mem1 [4096];
    logic [DW-1:0] mem0 [4096];
    logic [DW-1:0] ref_mem [4096];

    int checks = 0;
    int failures = 0;
    int we1 = 0;
    int m_ptr = 0;

    prog_mem_arbiter #(.DW(DW), .AW(AW), .NC(NC), .HOST_PRIO(1)) dut (
        .CLK(CLK), .RST(RST), .C_REQ(c_req), .C_A(c_a), .C_ACK(c_ack),
        .H_REQ(h_req), .H_WE(h_we), .H_A(h_a), .H_DI(h_di), .H_ACK(h_ack),
        .RDQ(rdq), .MEM_A(mem_a), .MEM_WE(mem_we), .MEM_DI(mem_di), .MEM_DQ(mem_dq),
        .BUSY(busy), .GNT_ID(gnt_id)
    );

    prog_mem_arbiter #(.DW(DW), .AW(AW), .NC(NC), .HOST_PRIO(0)) dut0 (
        .CLK(CLK), .RST(RST), .C_REQ(c_req0), .C_A(c_a0), .C_ACK(c_ack0),
        .H_REQ(h_req0), .H_WE(h_we0), .H_A(h_a0), .H_DI(h_di0), .H_ACK(h_ack0),
        .RDQ(rdq0), .MEM_A(mem_a0), .MEM_WE(mem_we0), .MEM_DI(mem_di0), .MEM_DQ(mem_dq0),
        .BUSY(busy0), .GNT_ID(gnt_id0)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 7919 + 32'h15A3) ^ 18'h2A5A5;
    endfunction

    assign mem_dq  = mem1[mem_a];
    assign mem_dq0 = mem0[mem_a0];

    initial begin
        for (int a = 0; a < 4096; a++) mem1[a] = init_word(a);
        forever begin
            @(posedge CLK);
            if (mem_we) mem1[mem_a] = mem_di;
        end
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem0[a] = init_word(a);
        forever begin
            @(posedge CLK);
            if (mem_we0) mem0[mem_a0] = mem_di0;
        end
    end

    // Winner by the arbitration rules: host first when prioritised, else first requesting
    // slot at or after ptr among prio ? NC : NC+1 slots (host is slot NC). 15 = host.
    function automatic int exp_winner(input bit prio, input logic hreq, input logic [NC-1:0] creq, input int ptr);
        int ns;
        ns = prio ? NC : NC + 1;
        if (prio && hreq) return 15;
        for (int k = 0; k < ns; k++) begin
            int s;
            s = (ptr + k) % ns;
            if (s == NC) begin
                if (hreq) return 15;
            end else if (creq[s]) begin
                return s;
            end
        end
        return -1;
    endfunction

    function automatic int decode(input logic [NC-1:0] ca, input logic ha);
        if (ha && ca == '0) return 15;
        if (!ha && $onehot(ca)) begin
            for (int i = 0; i < NC; i++) if (ca[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 12'hFFF;
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic step();
        if (mem_we) we1++;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input bit sel, output int cyc);
        cyc = 0;
        while (cyc < 12) begin
            step();
            cyc++;
            if (sel ? (c_ack0 != '0 || h_ack0) : (c_ack != '0 || h_ack)) break;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        c_req = '0; c_a = '0; h_req = 1'b0; h_we = 1'b0; h_a = '0; h_di = '0;
        c_req0 = '0; c_a0 = '0; h_req0 = 1'b0; h_we0 = 1'b0; h_a0 = '0; h_di0 = '0;
        step(); step();
        checks++;
        if ({c_ack, h_ack, mem_we, busy, gnt_id} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got c_ack=%b h_ack=%b we=%b busy=%b gnt=%h exp all 0", c_ack, h_ack, mem_we, busy, gnt_id);
        end
        checks++;
        if ({mem_a, mem_di, rdq} !== '0) begin
            failures++;
            $display("FAIL reset_data got mem_a=%h mem_di=%h rdq=%h exp 0", mem_a, mem_di, rdq);
        end
        checks++;
        if (busy0 !== 1'b0 || gnt_id0 !== 4'h0) begin
            failures++;
            $display("FAIL reset_dut0 got busy=%b gnt=%h exp 0/0", busy0, gnt_id0);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_abort();
        h_we = 1'b1; h_a = 12'h0A0; h_di = 18'h12345; h_req = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || mem_we !== 1'b1 || gnt_id !== 4'hF) begin
            failures++;
            $display("FAIL abort_granted got busy=%b we=%b gnt=%h exp 1/1/F", busy, mem_we, gnt_id);
        end
        RST = 1'b1;
        h_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_we_gate got %b exp 0", mem_we);
        end
        step(); step();
        checks++;
        if ({c_ack, h_ack, mem_we, busy, gnt_id, mem_a, mem_di, rdq} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got h_ack=%b we=%b busy=%b gnt=%h mem_a=%h exp all 0", h_ack, mem_we, busy, gnt_id, mem_a);
        end
        RST = 1'b0;
        m_ptr = 0;
        step();
        checks++;
        if (busy !== 1'b0 || h_ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got busy=%b h_ack=%b exp 0/0", busy, h_ack);
        end
    endtask

    task automatic test_single_core();
        int cyc;
        c_a[1*AW +: AW] = 12'h005;
        c_req = 4'b0010;
        we1 = 0;
        wait_ack(1'b0, cyc);
        checks++;
        if (cyc != 2 || c_ack !== 4'b0010 || h_ack !== 1'b0) begin
            failures++;
            $display("FAIL single_ack got cyc=%0d c_ack=%b h_ack=%b exp 2/0010/0", cyc, c_ack, h_ack);
        end
        checks++;
        if (rdq !== ref_mem[12'h005] || we1 != 0 || gnt_id !== 4'h1) begin
            failures++;
            $display("FAIL single_data got rdq=%h we_cycles=%0d gnt=%h exp %h/0/1", rdq, we1, gnt_id, ref_mem[12'h005]);
        end
        c_req = '0;
        m_ptr = 2;
        step();
        checks++;
        if (c_ack !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release got c_ack=%b busy=%b exp 0/0", c_ack, busy);
        end
    endtask

    task automatic test_host_priority();
        int cyc;
        h_we = 1'b1; h_a = 12'h00B; h_di = 18'h3ABCD; h_req = 1'b1;
        c_a[0 +: AW] = 12'h00B; c_req = 4'b0001;
        we1 = 0;
        wait_ack(1'b0, cyc);
        checks++;
        if (cyc != 2 || h_ack !== 1'b1 || c_ack !== '0 || we1 != 1 || gnt_id !== 4'hF) begin
            failures++;
            $display("FAIL host_first got cyc=%0d h_ack=%b c_ack=%b we_cycles=%0d gnt=%h exp 2/1/0/1/F", cyc, h_ack, c_ack, we1, gnt_id);
        end
        ref_mem[12'h00B] = 18'h3ABCD;
        h_req = 1'b0;
        we1 = 0;
        wait_ack(1'b0, cyc);
        checks++;
        if (cyc != 3 || c_ack !== 4'b0001 || rdq !== 18'h3ABCD || we1 != 0) begin
            failures++;
            $display("FAIL host_then_core got cyc=%0d c_ack=%b rdq=%h we_cycles=%0d exp 3/0001/3abcd/0", cyc, c_ack, rdq, we1);
        end
        c_req = '0;
        m_ptr = 1;
        step();
    endtask

    task automatic test_boundary();
        int cyc;
        h_we = 1'b0; h_a = 12'hFFF; h_req = 1'b1;
        step();
        checks++;
        if (mem_a !== 12'hFFF || mem_we !== 1'b0 || gnt_id !== 4'hF) begin
            failures++;
            $display("FAIL bnd_fff_access got mem_a=%h we=%b gnt=%h exp fff/0/F", mem_a, mem_we, gnt_id);
        end
        step();
        checks++;
        if (h_ack !== 1'b1 || rdq !== ref_mem[12'hFFF]) begin
            failures++;
            $display("FAIL bnd_fff_read got h_ack=%b rdq=%h exp 1/%h", h_ack, rdq, ref_mem[12'hFFF]);
        end
        h_req = 1'b0;
        step();
        h_a = 12'h0A0; h_req = 1'b1;
        wait_ack(1'b0, cyc);
        checks++;
        if (h_ack !== 1'b1 || rdq !== ref_mem[12'h0A0]) begin
            failures++;
            $display("FAIL bnd_aborted_write got h_ack=%b rdq=%h exp 1/%h", h_ack, rdq, ref_mem[12'h0A0]);
        end
        h_req = 1'b0;
        step();
        c_a[3*AW +: AW] = 12'h7C1; c_req = 4'b1000;
        step();
        checks++;
        if (gnt_id !== 4'h3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bnd_drop_grant got gnt=%h busy=%b exp 3/1", gnt_id, busy);
        end
        c_req = '0;
        step();
        checks++;
        if (c_ack !== 4'b1000 || rdq !== ref_mem[12'h7C1]) begin
            failures++;
            $display("FAIL bnd_drop_ack got c_ack=%b rdq=%h exp 1000/%h", c_ack, rdq, ref_mem[12'h7C1]);
        end
        m_ptr = 0;
        step();
        checks++;
        if (c_ack !== '0) begin
            failures++;
            $display("FAIL bnd_drop_pulse got c_ack=%b exp 0000", c_ack);
        end
    endtask

    task automatic test_fairness();
        int cyc, obs;
        for (int i = 0; i < NC; i++) c_a[i*AW +: AW] = AW'(12'h100 + i);
        c_req = 4'b1111;
        for (int n = 0; n < 2 * NC; n++) begin
            wait_ack(1'b0, cyc);
            obs = decode(c_ack, h_ack);
            checks++;
            if (cyc != 2 || obs != n % NC || rdq !== ref_mem[12'h100 + n % NC]) begin
                failures++;
                $display("FAIL fair_order[%0d] got cyc=%0d winner=%0d rdq=%h exp 2/%0d/%h", n, cyc, obs, rdq, n % NC, ref_mem[12'h100 + n % NC]);
            end
            if (obs >= 0 && obs < NC) c_req[obs] = 1'b0;
            step();
            c_req = 4'b1111;
        end
        c_req = '0;
        m_ptr = 0;
        step();
    endtask

    task automatic test_random();
        int cyc, obs, exp;
        logic [AW-1:0] ra;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NC; i++) begin
                if (!c_req[i] && $urandom_range(0, 1) == 1) begin
                    c_a[i*AW +: AW] = rnd_addr();
                    c_req[i] = 1'b1;
                end
            end
            if (!h_req && $urandom_range(0, 2) == 0) begin
                h_a = rnd_addr(); h_we = 1'($urandom_range(0, 1)); h_di = DW'($urandom); h_req = 1'b1;
            end
            if (!h_req && c_req == '0) begin
                c_a[0 +: AW] = rnd_addr();
                c_req[0] = 1'b1;
            end
            exp = exp_winner(1'b1, h_req, c_req, m_ptr);
            we1 = 0;
            wait_ack(1'b0, cyc);
            obs = decode(c_ack, h_ack);
            checks++;
            if (cyc != 2 || obs != exp) begin
                failures++;
                $display("FAIL rand_grant[%0d] got cyc=%0d winner=%0d exp 2/%0d", n, cyc, obs, exp);
            end
            if (exp == 15) begin
                checks++;
                if (h_we) begin
                    if (we1 != 1) begin
                        failures++;
                        $display("FAIL rand_host_write[%0d] got we_cycles=%0d exp 1", n, we1);
                    end
                    ref_mem[h_a] = h_di;
                end else if (we1 != 0 || rdq !== ref_mem[h_a]) begin
                    failures++;
                    $display("FAIL rand_host_read[%0d] got rdq=%h we_cycles=%0d exp %h/0", n, rdq, we1, ref_mem[h_a]);
                end
                h_req = 1'b0;
            end else if (exp >= 0) begin
                ra = c_a[exp*AW +: AW];
                checks++;
                if (we1 != 0 || rdq !== ref_mem[ra]) begin
                    failures++;
                    $display("FAIL rand_core_read[%0d] got rdq=%h we_cycles=%0d exp %h/0", n, rdq, we1, ref_mem[ra]);
                end
                c_req[exp] = 1'b0;
                m_ptr = (exp + 1) % NC;
            end
            step();
        end
        c_req = '0;
        h_req = 1'b0;
        step();
    endtask

    task automatic test_rotation_prio0();
        int cyc, obs, exp, hosts;
        logic [AW-1:0] ea;
        hosts = 0;
        for (int i = 0; i < NC; i++) c_a0[i*AW +: AW] = AW'(16 * i + 1);
        h_a0 = 12'h0F0; h_we0 = 1'b0;
        c_req0 = 4'b1111; h_req0 = 1'b1;
        for (int n = 0; n < 2 * (NC + 1); n++) begin
            wait_ack(1'b1, cyc);
            obs = decode(c_ack0, h_ack0);
            exp = (n % (NC + 1) == NC) ? 15 : n % (NC + 1);
            ea = (exp == 15) ? 12'h0F0 : AW'(16 * exp + 1);
            if (obs == 15) hosts++;
            checks++;
            if (cyc != 2 || obs != exp || gnt_id0 !== 4'(exp) || rdq0 !== init_word(int'(ea))) begin
                failures++;
                $display("FAIL rot_order[%0d] got cyc=%0d winner=%0d gnt=%h rdq=%h exp 2/%0d/%h", n, cyc, obs, gnt_id0, rdq0, exp, init_word(int'(ea)));
            end
            if (obs == 15) h_req0 = 1'b0;
            else if (obs >= 0) c_req0[obs] = 1'b0;
            step();
            c_req0 = 4'b1111; h_req0 = 1'b1;
        end
        checks++;
        if (hosts != 2) begin
            failures++;
            $display("FAIL rot_host_share got %0d host grants exp 2", hosts);
        end
        c_req0 = '0; h_req0 = 1'b0;
        step();
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(a);
        test_reset();
        test_abort();
        test_single_core();
        test_host_priority();
        test_boundary();
        test_fairness();
        test_random();
        test_rotation_prio0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
